// File: rtl/usb_bus_reset_detect.sv
// USB full-speed bus reset / suspend detector on the raw D+/D- pair.
// Drives an active-low reset for the USB core and a suspend flag for power management.
module usb_bus_reset_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int T_RESET     = 120,
  parameter int T_SUSPEND   = 144000
) (
  input  logic clk,
  input  logic reset_in_n,
  input  logic d_p,
  input  logic d_n,
  output logic usb_reset_n,
  output logic suspend,
  output logic se0
);

  localparam int CW = $clog2(T_SUSPEND + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(T_SUSPEND);
  localparam logic [CW-1:0] CNT_RESET = CW'(T_RESET);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (T_RESET < 1 || T_RESET >= T_SUSPEND) begin : g_bad_timing
      $error("usb_bus_reset_detect: need 1 <= T_RESET < T_SUSPEND");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("usb_bus_reset_detect: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    BUS_RESET = 2'd1,
    SUSPENDED = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] p_sync;
  logic [SYNC_STAGES-1:0] n_sync;
  logic                   j_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  logic [CW-1:0]          cnt_next;
  logic                   line_p;
  logic                   line_n;
  logic                   line_se0;
  logic                   line_j;

  assign line_p   = p_sync[SYNC_STAGES-1];
  assign line_n   = n_sync[SYNC_STAGES-1];
  assign line_se0 = !line_p && !line_n;
  assign line_j   = line_p && !line_n;

  // se0 and j_q hold the previous sample's class, so a match means the run continues.
  always_comb begin
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    cnt_next = '0;
    if (line_se0) begin
      cnt_next = se0 ? cnt_inc : CNT_ONE;
    end else if (line_j) begin
      cnt_next = j_q ? cnt_inc : CNT_ONE;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACTIVE: begin
        if (line_se0 && cnt_next >= CNT_RESET) begin
          state_next = BUS_RESET;
        end else if (line_j && cnt_next == CNT_MAX) begin
          state_next = SUSPENDED;
        end
      end
      BUS_RESET: if (!line_se0) state_next = ACTIVE;
      SUSPENDED: if (!line_j)   state_next = ACTIVE;
      default:   state_next = ACTIVE;
    endcase
  end

  // Sync flops reset to J so that leaving reset never looks like an SE0.
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      p_sync      <= '1;
      n_sync      <= '0;
      j_q         <= 1'b0;
      se0         <= 1'b0;
      cnt         <= '0;
      state       <= ACTIVE;
      usb_reset_n <= 1'b0;
      suspend     <= 1'b0;
    end else begin
      p_sync      <= {p_sync[SYNC_STAGES-2:0], d_p};
      n_sync      <= {n_sync[SYNC_STAGES-2:0], d_n};
      j_q         <= line_j;
      se0         <= line_se0;
      cnt         <= cnt_next;
      state       <= state_next;
      usb_reset_n <= (state_next != BUS_RESET);
      suspend     <= (state_next == SUSPENDED);
    end
  end

endmodule

// File: tb/tb_usb_bus_reset_detect.sv
// Bench for usb_bus_reset_detect: a segment table with hand-derived end values,
// reset-in-state sequences, EOP traffic and random line segments against a run-length model.
module tb_usb_bus_reset_detect;

  localparam int SYNC    = 2;
  localparam int T_RST   = 120;
  localparam int T_SUSP  = 1000;

  localparam int C_SE0  = 0;
  localparam int C_J    = 1;
  localparam int C_OTH  = 2;
  localparam int C_NONE = 3;

  localparam int M_ACTIVE = 0;
  localparam int M_RESET  = 1;
  localparam int M_SUSP   = 2;

  logic clk;
  logic reset_in_n;
  logic d_p;
  logic d_n;
  logic usb_reset_n;
  logic suspend;
  logic se0;

  usb_bus_reset_detect #(
    .SYNC_STAGES(SYNC),
    .T_RESET(T_RST),
    .T_SUSPEND(T_SUSP)
  ) dut (
    .clk(clk),
    .reset_in_n(reset_in_n),
    .d_p(d_p),
    .d_n(d_n),
    .usb_reset_n(usb_reset_n),
    .suspend(suspend),
    .se0(se0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      if (fail_cnt <= 50) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line history as a delay queue of {p,n}; the decision uses the length of the
  // current run of identical line classes (unbounded integer).
  logic [1:0] pipe_q[$];
  int m_prev;
  int m_run;
  int m_mode;
  logic m_rst_n;
  logic m_susp;
  logic m_se0;

  function automatic int classify(input logic [1:0] pn);
    if (pn == 2'b00) return C_SE0;
    if (pn == 2'b10) return C_J;
    return C_OTH;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    for (int i = 0; i < SYNC; i++) pipe_q.push_back(2'b10);
    m_prev  = C_NONE;
    m_run   = 0;
    m_mode  = M_ACTIVE;
    m_rst_n = 1'b0;
    m_susp  = 1'b0;
    m_se0   = 1'b0;
  endtask

  task automatic model_edge(input logic dp, input logic dn);
    int cls;
    cls = classify(pipe_q.pop_front());
    pipe_q.push_back({dp, dn});
    if (cls != C_OTH && cls == m_prev) m_run++;
    else m_run = (cls == C_OTH) ? 0 : 1;
    m_prev = cls;
    case (m_mode)
      M_ACTIVE: begin
        if (cls == C_SE0 && m_run >= T_RST) m_mode = M_RESET;
        else if (cls == C_J && m_run >= T_SUSP) m_mode = M_SUSP;
      end
      M_RESET: if (cls != C_SE0) m_mode = M_ACTIVE;
      default: if (cls != C_J) m_mode = M_ACTIVE;
    endcase
    m_rst_n = (m_mode != M_RESET);
    m_susp  = (m_mode == M_SUSP);
    m_se0   = (cls == C_SE0);
  endtask

  // ---------------- driver ----------------
  bit seen_rst;
  bit seen_susp;
  int se0_hi;

  task automatic cycle(input logic dp, input logic dn);
    d_p = dp;
    d_n = dn;
    model_edge(dp, dn);
    @(posedge clk);
    #1;
    check("usb_reset_n", usb_reset_n, m_rst_n);
    check("suspend", suspend, m_susp);
    check("se0", se0, m_se0);
    if (!usb_reset_n) seen_rst = 1'b1;
    if (suspend) seen_susp = 1'b1;
    if (se0) se0_hi++;
  endtask

  task automatic hold(input logic dp, input logic dn, input int len);
    for (int i = 0; i < len; i++) cycle(dp, dn);
  endtask

  // Assert reset at a point away from the clock edge, check the immediate effect,
  // then release with J on the line and check the first edge.
  task automatic apply_reset(input string tag);
    reset_in_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_n_async"}, usb_reset_n, 1'b0);
    check({tag, "_susp_async"}, suspend, 1'b0);
    check({tag, "_se0_async"}, se0, 1'b0);
    d_p = 1'b1;
    d_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_rst_n_held"}, usb_reset_n, 1'b0);
    reset_in_n = 1'b1;
    cycle(1'b1, 1'b0);
    check({tag, "_rst_n_release"}, usb_reset_n, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic dp;
    logic dn;
    int   len;
    logic rst_n;
    logic susp;
    logic se0;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n_eop;
    int kind;
    int len;

    // Each row holds the line for len cycles; expected values are at the row's end,
    // remembering the line reaches the decoder SYNC cycles late.
    tbl.push_back('{1'b1, 1'b0, 20,   1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 119,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10,   1'b1, 1'b0, 1'b0});  // 119 SE0 then J: no reset
    tbl.push_back('{1'b0, 1'b0, 120,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1,    1'b1, 1'b0, 1'b1});  // 119th SE0 registered
    tbl.push_back('{1'b0, 1'b0, 1,    1'b0, 1'b0, 1'b1});  // 120th SE0: reset asserts
    tbl.push_back('{1'b0, 1'b0, 1000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 2,    1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b0, 1'b0});  // first J sample releases
    tbl.push_back('{1'b1, 1'b0, 996,  1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    1'b1, 1'b0, 1'b0});  // single K on the pins
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b0, 1'b0});  // 999 J samples so far
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b0, 1'b0});  // K sample restarts J run
    tbl.push_back('{1'b1, 1'b0, 999,  1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b1, 1'b0});  // 1000th J: suspend
    tbl.push_back('{1'b1, 1'b0, 50,   1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1,    1'b1, 1'b0, 1'b0});  // K sample clears suspend
    tbl.push_back('{1'b1, 1'b0, 1100, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2,    1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1,    1'b1, 1'b0, 1'b1});  // first SE0 leaves suspend
    tbl.push_back('{1'b0, 1'b0, 118,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1,    1'b0, 1'b0, 1'b1});  // 120th SE0 counted from 1

    // Power-on reset with line J.
    reset_in_n = 1'b0;
    d_p = 1'b1;
    d_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("por_rst_n", usb_reset_n, 1'b0);
    check("por_susp", suspend, 1'b0);
    check("por_se0", se0, 1'b0);
    reset_in_n = 1'b1;
    cycle(1'b1, 1'b0);
    check("por_rst_n_release", usb_reset_n, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      hold(tbl[i].dp, tbl[i].dn, tbl[i].len);
      check($sformatf("tbl%0d_rst_n", i), usb_reset_n, tbl[i].rst_n);
      check($sformatf("tbl%0d_susp", i), suspend, tbl[i].susp);
      check($sformatf("tbl%0d_se0", i), se0, tbl[i].se0);
    end

    // Table ends in bus reset: reset the block there.
    apply_reset("rst_in_bus_reset");

    // Reach suspend, then reset the block there.
    hold(1'b1, 1'b0, T_SUSP + SYNC + 5);
    check("suspend_reached", suspend, 1'b1);
    apply_reset("rst_in_suspend");

    // EOP traffic: 4 SE0, 3 J, then short K/J activity.
    seen_rst  = 1'b0;
    seen_susp = 1'b0;
    se0_hi    = 0;
    n_eop     = 0;
    for (int c = 0; c < 10000; ) begin
      hold(1'b0, 1'b0, 4);
      hold(1'b1, 1'b0, 3);
      n_eop++;
      len = $urandom_range(2, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 1) cycle(1'b1, 1'b0);
        else cycle(1'b0, 1'b1);
      end
      c += 7 + len;
    end
    check("eop_no_reset", seen_rst, 1'b0);
    check("eop_no_suspend", seen_susp, 1'b0);
    check("eop_se0_cycles", se0_hi, 4 * n_eop);

    // Random line segments, including runs near both thresholds.
    for (int s = 0; s < 80; s++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: hold(1'b0, 1'b0, $urandom_range(1, 6));
        1: hold(1'b0, 1'b0, $urandom_range(T_RST - 10, T_RST + 20));
        2: hold(1'b1, 1'b0, $urandom_range(1, 30));
        3: hold(1'b1, 1'b0, $urandom_range(T_SUSP - 50, T_SUSP + 50));
        4: hold(1'b0, 1'b1, $urandom_range(1, 10));
        default: hold(1'b1, 1'b1, $urandom_range(1, 3));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
